// File: rtl/puf_challenge_ctrl.sv
// Challenge sequencer for the dual-adder/PDL arbiter PUF: precharge, apply, settle, sample, respond.
// Optional per-bit majority voting over NUM_EVALS evaluations is compiled in with PUF_MAJORITY_VOTE_EN.
module puf_challenge_ctrl #(
    parameter int PRECHARGE_CYCLES = 4,
    parameter int SETTLE_CYCLES    = 8,
    parameter int NUM_EVALS        = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         chal_valid,
    output logic         chal_ready,
    input  logic [31:0]  chal_a,
    input  logic [31:0]  chal_b,
    input  logic [127:0] chal_cfg1,
    input  logic [127:0] chal_cfg2,
    output logic [31:0]  puf_a,
    output logic [31:0]  puf_b,
    output logic [127:0] puf_config1,
    output logic [127:0] puf_config2,
    input  logic [31:0]  puf_c,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [31:0]  resp_data,
    output logic [31:0]  resp_unstable,
    output logic         busy,
    output logic [2:0]   dbg_state
);

`ifdef PUF_MAJORITY_VOTE_EN
    localparam int NEVAL = NUM_EVALS;
`else
    localparam int NEVAL = (NUM_EVALS > 0) ? 1 : 1;
`endif
    localparam int PMAX = (PRECHARGE_CYCLES > SETTLE_CYCLES) ? PRECHARGE_CYCLES : SETTLE_CYCLES;
    localparam int CW   = $clog2(PMAX + 1);
    localparam int EW   = $clog2(NEVAL + 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(PRECHARGE_CYCLES - 1);
    localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [EW:0]   NEVAL_W  = (EW + 1)'(NEVAL);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        PRECHARGE    = 3'd1,
        APPLY_SETTLE = 3'd2,
        SAMPLE       = 3'd3,
        DONE         = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [EW-1:0]  eval_q, eval_d;
    logic [EW:0]    eval_inc;
    logic [31:0]    a_q, a_d, b_q, b_d;
    logic [127:0]   cfg1_q, cfg1_d, cfg2_q, cfg2_d;
`ifdef PUF_MAJORITY_VOTE_EN
    logic [EW-1:0]  ones_q [32];
    logic [EW-1:0]  ones_d [32];
    localparam logic [EW-1:0] HALF = EW'(NUM_EVALS / 2);
    localparam logic [EW-1:0] FULL = EW'(NUM_EVALS);
`else
    logic [31:0]    samp_q, samp_d;
`endif

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // resp_* hold steady while resp_valid is high and resp_ready is low.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        eval_d   = eval_q;
        a_d      = a_q;
        b_d      = b_q;
        cfg1_d   = cfg1_q;
        cfg2_d   = cfg2_q;
        eval_inc = {1'b0, eval_q} + 1'b1;
`ifdef PUF_MAJORITY_VOTE_EN
        ones_d   = ones_q;
`else
        samp_d   = samp_q;
`endif
        case (state_q)
            IDLE: begin
                if (chal_valid) begin
                    a_d     = chal_a;
                    b_d     = chal_b;
                    cfg1_d  = chal_cfg1;
                    cfg2_d  = chal_cfg2;
                    cnt_d   = '0;
                    eval_d  = '0;
`ifdef PUF_MAJORITY_VOTE_EN
                    for (int i = 0; i < 32; i++) ones_d[i] = '0;
`endif
                    state_d = PRECHARGE;
                end
            end
            PRECHARGE: begin
                if (cnt_q == PRE_LAST) begin
                    cnt_d   = '0;
                    state_d = APPLY_SETTLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            APPLY_SETTLE: begin
                if (cnt_q == SET_LAST) begin
                    cnt_d   = '0;
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SAMPLE: begin
                eval_d = eval_inc[EW-1:0];
`ifdef PUF_MAJORITY_VOTE_EN
                for (int i = 0; i < 32; i++) ones_d[i] = ones_q[i] + EW'(puf_c[i]);
`else
                samp_d = puf_c;
`endif
                state_d = (eval_inc < NEVAL_W) ? PRECHARGE : DONE;
            end
            DONE: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            eval_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cfg1_q  <= '0;
            cfg2_q  <= '0;
`ifdef PUF_MAJORITY_VOTE_EN
            ones_q  <= '{default: '0};
`else
            samp_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            eval_q  <= eval_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cfg1_q  <= cfg1_d;
            cfg2_q  <= cfg2_d;
`ifdef PUF_MAJORITY_VOTE_EN
            ones_q  <= ones_d;
`else
            samp_q  <= samp_d;
`endif
        end
    end

    // Operands stay applied through SAMPLE so the arbiters see a stable race when captured.
    always_comb begin
        chal_ready    = (state_q == IDLE);
        busy          = (state_q != IDLE);
        resp_valid    = (state_q == DONE);
        dbg_state     = state_q;
        puf_config1   = cfg1_q;
        puf_config2   = cfg2_q;
        puf_a         = '0;
        puf_b         = '0;
        resp_data     = '0;
        resp_unstable = '0;
        if (state_q == APPLY_SETTLE || state_q == SAMPLE) begin
            puf_a = a_q;
            puf_b = b_q;
        end
        if (state_q == DONE) begin
`ifdef PUF_MAJORITY_VOTE_EN
            for (int i = 0; i < 32; i++) begin
                resp_data[i]     = (ones_q[i] > HALF);
                resp_unstable[i] = (ones_q[i] != '0) && (ones_q[i] != FULL);
            end
`else
            resp_data = samp_q;
`endif
        end
    end

endmodule

// File: tb/tb_puf_challenge_ctrl.sv
// Directed-sequence bench for puf_challenge_ctrl with a scripted per-evaluation puf_c model
// and a vote reference computed by counting bits; builds with or without PUF_MAJORITY_VOTE_EN.
module tb_puf_challenge_ctrl;

    localparam int P = 4;
    localparam int S = 8;
`ifdef PUF_MAJORITY_VOTE_EN
    localparam int NEV  = 7;
    localparam bit VOTE = 1'b1;
`else
    localparam int NEV  = 1;
    localparam bit VOTE = 1'b0;
`endif
    localparam int EVAL_LEN = P + S + 1;
    localparam int LAT      = NEV * EVAL_LEN;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         chal_valid;
    logic         chal_ready;
    logic [31:0]  chal_a, chal_b;
    logic [127:0] chal_cfg1, chal_cfg2;
    logic [31:0]  puf_a, puf_b;
    logic [127:0] puf_config1, puf_config2;
    logic [31:0]  puf_c;
    logic         resp_valid;
    logic         resp_ready;
    logic [31:0]  resp_data, resp_unstable;
    logic         busy;
    logic [2:0]   dbg_state;

    int errors = 0;
    int checks = 0;
    logic [31:0] ev [7];

    puf_challenge_ctrl #(.PRECHARGE_CYCLES(P), .SETTLE_CYCLES(S), .NUM_EVALS(7)) dut (
        .clk(clk), .rst_n(rst_n), .chal_valid(chal_valid), .chal_ready(chal_ready),
        .chal_a(chal_a), .chal_b(chal_b), .chal_cfg1(chal_cfg1), .chal_cfg2(chal_cfg2),
        .puf_a(puf_a), .puf_b(puf_b), .puf_config1(puf_config1), .puf_config2(puf_config2),
        .puf_c(puf_c), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_unstable(resp_unstable), .busy(busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset(input string where);
        chk({where, "_chal_ready"}, 128'(chal_ready), 128'(1'b1));
        chk({where, "_busy"}, 128'(busy), 128'(1'b0));
        chk({where, "_resp_valid"}, 128'(resp_valid), 128'(1'b0));
        chk({where, "_resp_data"}, 128'(resp_data), 128'(0));
        chk({where, "_resp_unstable"}, 128'(resp_unstable), 128'(0));
        chk({where, "_puf_a"}, 128'(puf_a), 128'(0));
        chk({where, "_puf_b"}, 128'(puf_b), 128'(0));
        chk({where, "_cfg1"}, puf_config1, 128'(0));
        chk({where, "_cfg2"}, puf_config2, 128'(0));
    endtask

    // Reference: count ones per bit over the evaluations actually performed.
    function automatic void model(output logic [31:0] d, output logic [31:0] u);
        for (int i = 0; i < 32; i++) begin
            int n = 0;
            for (int k = 0; k < NEV; k++) n += int'(ev[k][i]);
            d[i] = (n > NEV / 2);
            u[i] = VOTE && (n != 0) && (n != NEV);
        end
    endfunction

    // abort_at >= 0 asserts reset in that cycle after the accept edge and returns.
    task automatic run_chal(input logic [31:0] a, input logic [31:0] b,
                            input logic [127:0] c1, input logic [127:0] c2,
                            input int hold, input int abort_at);
        logic [31:0] ed, eu;
        int e, r;
        model(ed, eu);
        @(posedge clk); #1;
        chal_valid = 1'b1; chal_a = a; chal_b = b; chal_cfg1 = c1; chal_cfg2 = c2;
        resp_ready = (hold == 0);
        @(posedge clk); #1;
        chal_valid = 1'b0; chal_a = $urandom; chal_b = $urandom;
        chal_cfg1 = {$urandom, $urandom, $urandom, $urandom};
        for (int c = 0; c < LAT; c++) begin
            e = c / EVAL_LEN;
            r = c % EVAL_LEN;
            puf_c = (r == EVAL_LEN - 1) ? ev[e] : $urandom;
            if (c == abort_at) begin
                #2 rst_n = 1'b0;
                #1 chk_reset("midrst");
                return;
            end
            @(negedge clk);
            chk("run_busy", 128'(busy), 128'(1'b1));
            chk("run_chal_ready", 128'(chal_ready), 128'(1'b0));
            chk("run_resp_valid", 128'(resp_valid), 128'(1'b0));
            chk("run_cfg1", puf_config1, c1);
            chk("run_cfg2", puf_config2, c2);
            if (r < P) begin
                chk("pre_puf_a", 128'(puf_a), 128'(0));
                chk("pre_puf_b", 128'(puf_b), 128'(0));
            end else if (r < P + S) begin
                chk("settle_puf_a", 128'(puf_a), 128'(a));
                chk("settle_puf_b", 128'(puf_b), 128'(b));
            end
            @(posedge clk); #1;
        end
        puf_c = $urandom;
        @(negedge clk);
        chk("done_resp_valid", 128'(resp_valid), 128'(1'b1));
        chk("done_resp_data", 128'(resp_data), 128'(ed));
        chk("done_resp_unstable", 128'(resp_unstable), 128'(eu));
        chk("done_puf_a", 128'(puf_a), 128'(0));
        chk("done_chal_ready", 128'(chal_ready), 128'(1'b0));
        for (int h = 0; h < hold; h++) begin
            chal_valid = 1'b1;
            chal_a = $urandom;
            chal_cfg1 = {$urandom, $urandom, $urandom, $urandom};
            puf_c = $urandom;
            @(posedge clk);
            @(negedge clk);
            chk("bp_resp_valid", 128'(resp_valid), 128'(1'b1));
            chk("bp_resp_data", 128'(resp_data), 128'(ed));
            chk("bp_resp_unstable", 128'(resp_unstable), 128'(eu));
            chk("bp_chal_ready", 128'(chal_ready), 128'(1'b0));
            chk("bp_cfg1", puf_config1, c1);
        end
        chal_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        @(negedge clk);
        chk("post_chal_ready", 128'(chal_ready), 128'(1'b1));
        chk("post_busy", 128'(busy), 128'(1'b0));
        chk("post_resp_valid", 128'(resp_valid), 128'(1'b0));
        chk("post_puf_a", 128'(puf_a), 128'(0));
        chk("post_cfg1_hold", puf_config1, c1);
        chk("post_cfg2_hold", puf_config2, c2);
    endtask

    initial begin
        logic [127:0] c1, c2;
        rst_n = 1'b0; chal_valid = 1'b0; resp_ready = 1'b0;
        chal_a = '0; chal_b = '0; chal_cfg1 = '0; chal_cfg2 = '0; puf_c = '0;
        #12 chk_reset("reset");
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            puf_c = $urandom;
            @(negedge clk);
            chk("idle_chal_ready", 128'(chal_ready), 128'(1'b1));
            chk("idle_busy", 128'(busy), 128'(1'b0));
            chk("idle_puf_a", 128'(puf_a), 128'(0));
            chk("idle_resp_valid", 128'(resp_valid), 128'(1'b0));
        end

        // Constant response, handshake completes in the first DONE cycle.
        for (int k = 0; k < 7; k++) ev[k] = 32'hA5A5_5A5A;
        c1 = {$urandom, $urandom, $urandom, $urandom};
        c2 = {$urandom, $urandom, $urandom, $urandom};
        run_chal(32'h1234_5678, 32'h0F0F_0F0F, c1, c2, 0, -1);

        // Four ones then three zeros.
        for (int k = 0; k < 7; k++) ev[k] = (k < 4) ? 32'hFFFF_FFFF : 32'h0;
        run_chal($urandom, $urandom, c2, c1, 0, -1);

        // Three ones then four zeros, with 50 cycles of backpressure.
        for (int k = 0; k < 7; k++) ev[k] = (k < 3) ? 32'hFFFF_FFFF : 32'h0;
        c1 = {$urandom, $urandom, $urandom, $urandom};
        run_chal($urandom, $urandom, c1, c2, 50, -1);

        // Random evaluation words.
        for (int t = 0; t < 3; t++) begin
            for (int k = 0; k < 7; k++) ev[k] = $urandom;
            c1 = {$urandom, $urandom, $urandom, $urandom};
            c2 = {$urandom, $urandom, $urandom, $urandom};
            run_chal($urandom, $urandom, c1, c2, $urandom_range(0, 3), -1);
        end

        // Low byte only.
        for (int k = 0; k < 7; k++) ev[k] = 32'h0000_00FF;
        run_chal($urandom, $urandom, c1, c2, 0, -1);

        // Reset during the third settle window (or the only one without voting).
        for (int k = 0; k < 7; k++) ev[k] = 32'hFFFF_FFFF;
        run_chal($urandom, $urandom, c1, c2, 0, ((NEV > 2) ? 2 : NEV - 1) * EVAL_LEN + P + 3);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        resp_ready = 1'b0;
        @(negedge clk);
        chk_reset("after_rst");

        // Fresh challenge: stale all-ones votes would flip this to ones.
        for (int k = 0; k < 7; k++) ev[k] = (k < NEV / 2 + 1) ? 32'h0 : 32'hFFFF_FFFF;
        c1 = {$urandom, $urandom, $urandom, $urandom};
        run_chal(32'hDEAD_BEEF, 32'h0BAD_F00D, c1, c2, 2, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/puf_challenge_ctrl.md
# puf_challenge_ctrl

Sequencer that drives one challenge at a time into the dual-adder/PDL arbiter PUF and returns a response word. It sits between a host-side challenge stream (ethernet command path) and the PUF datapath top. It latches operand and PDL configuration words, precharges the race paths to zero, applies the operands, and waits for the arbiter flops to settle. It then samples the 32-bit response and optionally majority-votes over repeated evaluations.

## Interface
Parameters:
- PRECHARGE_CYCLES, 4: cycles with PUF operands forced to 0 before each evaluation; ≥1.
- SETTLE_CYCLES, 8: cycles between operand apply and response sample; ≥1.
- NUM_EVALS, 7: evaluations per challenge when voting is compiled in; odd, ≥1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- chal_valid  in  1  challenge offered.
- chal_ready  out  1  controller can accept a challenge (high only in IDLE).
- chal_a, chal_b  in  32 each  adder operands.
- chal_cfg1, chal_cfg2  in  128 each  PDL control words for paths 1/2.
- puf_a, puf_b  out  32 each  operands to PUF datapath.
- puf_config1, puf_config2  out  128 each  PDL config to PUF datapath.
- puf_c  in  32  arbiter latch outputs from PUF datapath.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts response.
- resp_data  out  32  response word.
- resp_unstable  out  32  per-bit flag: bit disagreed across evaluations.
- busy  out  1  high in any state except IDLE.

## Operation
- States: IDLE, PRECHARGE, APPLY_SETTLE, SAMPLE, DONE.
- IDLE: chal_ready=1. On chal_valid&chal_ready, register chal_a/b/cfg1/cfg2, clear vote counters and eval counter, and go to PRECHARGE.
- PRECHARGE: puf_a=puf_b=0 and puf_config* = latched configs, held for PRECHARGE_CYCLES cycles. Then go to APPLY_SETTLE.
- APPLY_SETTLE: puf_a/puf_b = latched operands for SETTLE_CYCLES cycles. Then go to SAMPLE.
- SAMPLE: one cycle. Register puf_c and add each bit into its per-bit ones-counter (width clog2(NUM_EVALS+1)). Increment the eval counter. If the eval count is below NUM_EVALS, go to PRECHARGE; otherwise go to DONE.
- DONE: resp_valid=1 with resp_data[i] = (ones[i] > NUM_EVALS/2) and resp_unstable[i] = (ones[i]≠0 && ones[i]≠NUM_EVALS). Outputs are held stable until resp_ready. On resp_valid&resp_ready, go to IDLE.
- puf_config* hold their last value in IDLE, so the PDLs are not re-toggled between challenges. puf_a/puf_b are 0 in IDLE and DONE.
- chal_valid outside IDLE is ignored; there is no queuing.
- puf_c is treated as asynchronous-ish latch output. It must be sampled only in SAMPLE, after the operands have been stable for SETTLE_CYCLES.

## Timing
- Reset values: state IDLE, chal_ready=1, busy=0, resp_valid=0, resp_data=0, resp_unstable=0, puf_a=puf_b=0, puf_config1=puf_config2=0, all counters 0.
- Per evaluation: PRECHARGE_CYCLES + SETTLE_CYCLES + 1 cycles.
- Latency from the accept edge to resp_valid high: NUM_EVALS·(PRECHARGE_CYCLES+SETTLE_CYCLES+1) cycles. With defaults this is 7·13 = 91.
- chal_ready falls the cycle after the accept edge. chal_ready rises the cycle after the response handshake.
- resp_ready may already be high when resp_valid rises. The handshake then completes in that first DONE cycle (DONE lasts 1 cycle).
- Reset asserted mid-operation immediately forces all reset values; the in-flight challenge and any partial votes are discarded. No response is produced for it.
- Counters never wrap: the eval counter saturates at NUM_EVALS by construction, and the ones-counters are sized to NUM_EVALS.

## Configuration
- PUF_MAJORITY_VOTE_EN defined: behaviour as above, NUM_EVALS evaluations per challenge, per-bit voting.
- PUF_MAJORITY_VOTE_EN undefined:
  - NUM_EVALS is ignored and exactly one evaluation is done.
  - resp_data is the single sampled puf_c.
  - resp_unstable is tied to 0 and no ones-counters are built.
  - Latency is PRECHARGE_CYCLES+SETTLE_CYCLES+1 (13 with defaults).

## Test plan
All scenarios use a bench model that returns puf_c per evaluation from a scripted list.
- Reset/idle check: after rst_n release, verify all reset values. chal_valid=0 for 20 cycles must give no state change and puf_a=0.
- Single challenge, voting on, model always returns 0xA5A5_5A5A: chal_a=0x1234_5678, chal_b=0x0F0F_0F0F. Expect the following:
  - puf_a=0 during every precharge window.
  - puf_a=0x1234_5678 during every settle window.
  - resp_valid at accept+91, resp_data=0xA5A5_5A5A, resp_unstable=0.
- Voting: model returns 0xFFFF_FFFF four times and 0x0000_0000 three times. Expect resp_data=0xFFFF_FFFF and resp_unstable=0xFFFF_FFFF. With the counts reversed (three/four), expect resp_data=0.
- Backpressure: hold resp_ready=0 for 50 cycles after resp_valid. Outputs must be stable, chal_ready=0, and a new chal_valid is ignored. After resp_ready=1, chal_ready=1 the next cycle.
- Reset mid-evaluation: assert rst_n=0 during the 3rd SETTLE. All outputs return to reset values asynchronously. After release, a fresh challenge completes with correct latency and no stale votes.
- Macro undefined build: model returns 0x0000_00FF. Expect resp_valid at accept+13, resp_data=0x0000_00FF, resp_unstable=0.
